// File: rtl/serial_pair_receiver_if.sv
// Handshake and data bundle between the dual shift-register pair, this
// receiver and its consumer.
interface serial_pair_receiver_if;
    logic       Start;
    logic       A_In;
    logic       B_In;
    logic       Ack;
    logic       Shift_En;
    logic       Busy;
    logic       Valid;
    logic [2:0] Count;
    logic [7:0] A_Data;
    logic [7:0] B_Data;

    // Receiver side
    modport slave (
        input  Start,
        input  A_In,
        input  B_In,
        input  Ack,
        output Shift_En,
        output Busy,
        output Valid,
        output Count,
        output A_Data,
        output B_Data
    );

    // Requester / sender / consumer side
    modport master (
        output Start,
        output A_In,
        output B_In,
        output Ack,
        input  Shift_En,
        input  Busy,
        input  Valid,
        input  Count,
        input  A_Data,
        input  B_Data
    );
endinterface

// File: rtl/serial_pair_receiver.sv
// Two-lane LSB-first serial-to-parallel receiver: drives the shared shift
// enable for eight cycles, assembles both bytes, then holds them until Ack.
module serial_pair_receiver (
    input  logic                  Clk,
    input  logic                  Reset_n,
    serial_pair_receiver_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] shreg_a;
    logic [7:0] shreg_b;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [2:0] count;
    logic       last_shift;

    assign last_shift = (count == 3'd7);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.Start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    if (bus.Ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Count wraps 7->0 on the capture edge, so it already reads 0 in DONE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shreg_a <= '0;
            shreg_b <= '0;
            data_a  <= '0;
            data_b  <= '0;
            count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        count <= '0;
                    end
                end
                SHIFT: begin
                    shreg_a <= {bus.A_In, shreg_a[7:1]};
                    shreg_b <= {bus.B_In, shreg_b[7:1]};
                    count   <= count + 3'd1;
                    if (last_shift) begin
                        data_a <= {bus.A_In, shreg_a[7:1]};
                        data_b <= {bus.B_In, shreg_b[7:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Shift_En = (state == SHIFT);
    assign bus.Busy     = (state == SHIFT) || (state == DONE);
    assign bus.Valid    = (state == DONE);
    assign bus.Count    = count;
    assign bus.A_Data   = data_a;
    assign bus.B_Data   = data_b;

endmodule

// File: tb/tb_serial_pair_receiver.sv
// Randomized self-checking bench for serial_pair_receiver with a behavioural
// sender model and a byte-level expectation of every transfer.
module tb_serial_pair_receiver;

    logic clk;
    logic rst_n;

    serial_pair_receiver_if bus ();

    serial_pair_receiver dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Expected contents of A_Data/B_Data at any moment.
    logic [7:0] held_a = 8'h00;
    logic [7:0] held_b = 8'h00;

    // Sender register pair: loads requested by tasks, shifted on enabled edges.
    logic [7:0]  load_a   = 8'h00;
    logic [7:0]  load_b   = 8'h00;
    int unsigned load_seq = 0;
    int unsigned applied  = 0;
    logic [7:0]  snd_a    = 8'h00;
    logic [7:0]  snd_b    = 8'h00;
    logic        se_prev  = 1'b0;

    always @(negedge clk) begin
        if (load_seq != applied) begin
            snd_a   = load_a;
            snd_b   = load_b;
            applied = load_seq;
        end else if (bus.Shift_En && se_prev) begin
            snd_a = snd_a >> 1;
            snd_b = snd_b >> 1;
        end
        se_prev  = bus.Shift_En;
        bus.A_In = snd_a[0];
        bus.B_In = snd_b[0];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_sender(input logic [7:0] a, input logic [7:0] b);
        load_a = a;
        load_b = b;
        load_seq++;
    endtask

    // One full transfer; flags are {Busy, Valid, Shift_En}.
    task automatic run_transfer(input logic [7:0] a, input logic [7:0] b,
                                input int unsigned ack_delay, input bit noise,
                                input bit start_on_ack);
        load_sender(a, b);
        if (noise) begin
            bus.Ack = 1'b1;
            @(negedge clk);
            check_eq("idle_ack_ignored", {bus.Busy, bus.Valid, bus.Shift_En}, 3'b000);
            bus.Ack = 1'b0;
        end
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("shift_flags", {bus.Busy, bus.Valid, bus.Shift_En}, 3'b101);
            check_eq("shift_count", bus.Count, k);
            check_eq("shift_hold", {bus.A_Data, bus.B_Data}, {held_a, held_b});
            if (noise) begin
                bus.Start = 1'($urandom_range(0, 1));
                bus.Ack   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        held_a  = a;
        held_b  = b;
        bus.Ack = 1'b0;
        for (int d = 0; d <= int'(ack_delay); d++) begin
            check_eq("done_flags", {bus.Busy, bus.Valid, bus.Shift_En}, 3'b110);
            check_eq("done_count", bus.Count, 0);
            check_eq("done_data", {bus.A_Data, bus.B_Data}, {held_a, held_b});
            if (d == int'(ack_delay)) begin
                bus.Ack   = 1'b1;
                bus.Start = start_on_ack;
            end else begin
                bus.Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
        end
        bus.Ack   = 1'b0;
        bus.Start = 1'b0;
        check_eq("idle_flags", {bus.Busy, bus.Valid, bus.Shift_En}, 3'b000);
        check_eq("idle_data", {bus.A_Data, bus.B_Data}, {held_a, held_b});
        @(negedge clk);
        check_eq("no_restart", {bus.Busy, bus.Shift_En, bus.Count}, 5'b0);
    endtask

    // Bounded wait for Valid with Start held high; also tracks the longest Shift_En run.
    task automatic await_valid(output int unsigned cycles, output int unsigned max_run);
        int unsigned run;
        run     = 0;
        max_run = 0;
        cycles  = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            run = bus.Shift_En ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (!bus.Valid) check_eq("b2b_hold", {bus.A_Data, bus.B_Data}, {held_a, held_b});
            if (bus.Valid) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic b2b_leg(input logic [7:0] a, input logic [7:0] b);
        int unsigned cycles;
        int unsigned max_run;
        load_sender(a, b);
        await_valid(cycles, max_run);
        // Start seen at the first edge, eight SHIFT cycles, Valid at the ninth negedge.
        check_eq("b2b_latency", cycles, 9);
        check_eq("b2b_max_shift_run", max_run, 8);
        held_a = a;
        held_b = b;
        check_eq("b2b_data", {bus.A_Data, bus.B_Data}, {held_a, held_b});
        repeat (2) begin
            @(negedge clk);
            check_eq("b2b_valid_held", {bus.Valid, bus.A_Data, bus.B_Data}, {1'b1, held_a, held_b});
        end
        bus.Ack = 1'b1;
        @(negedge clk);
        bus.Ack = 1'b0;
        check_eq("b2b_ack_idle", {bus.Busy, bus.Valid, bus.Shift_En}, 3'b000);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        rst_n     = 1'b0;

        repeat (6) begin
            bus.Start = 1'($urandom_range(0, 1));
            bus.Ack   = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("reset_outputs",
                     {bus.Busy, bus.Valid, bus.Shift_En, bus.Count, bus.A_Data, bus.B_Data}, 22'h0);
        end
        bus.Start = 1'b0;
        bus.Ack   = 1'b0;
        rst_n     = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("post_reset_idle", {bus.Busy, bus.Shift_En}, 2'b00);
        end

        run_transfer(8'h5A, 8'hC3, 1, 1'b0, 1'b0);

        bus.Start = 1'b1;
        b2b_leg(8'hFF, 8'h00);
        b2b_leg(8'h01, 8'h80);
        bus.Start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("b2b_stop", {bus.Busy, bus.Shift_En}, 2'b00);

        run_transfer(8'h96, 8'h69, 0, 1'b1, 1'b1);

        // Abort mid-transfer: reset must clear everything without waiting for an edge.
        load_sender(8'h77, 8'h11);
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_count", bus.Count, 4);
        #1 rst_n = 1'b0;
        #1;
        held_a = 8'h00;
        held_b = 8'h00;
        check_eq("mid_reset_outputs",
                 {bus.Busy, bus.Valid, bus.Shift_En, bus.Count, bus.A_Data, bus.B_Data}, 22'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_transfer(8'hA5, 8'h3C, 1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_transfer(8'($urandom), 8'($urandom), $urandom_range(0, 3), 1'b1,
                         1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_pair_receiver.md
# serial_pair_receiver

Two-lane serial-to-parallel receiver for the logic processor. It sits at the far end of the dual 8-bit shift-register pair (register A / register B serial outputs). It drives the shared shift enable for exactly eight cycles per transfer and deserializes both LSB-first bit streams into bytes. It then presents the bytes with a valid/acknowledge handshake.

## Interface
Parameters:
- none. Width is fixed at 8 bits per lane; the transfer length is fixed at 8 shifts.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  request a transfer; sampled only in IDLE
- A_In  in  1  serial bit from register A shift output
- B_In  in  1  serial bit from register B shift output
- Ack  in  1  consumer has taken A_Data/B_Data; sampled only in DONE
- Shift_En  out  1  shift enable to both sending registers; high only in SHIFT
- Busy  out  1  high in SHIFT and DONE
- Valid  out  1  high in DONE
- Count  out  3  number of bits captured so far in the current transfer
- A_Data  out  8  assembled lane A byte
- B_Data  out  8  assembled lane B byte

## Operation
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from state only (Moore); there are no combinational input-to-output paths.
- IDLE:
  - Shift_En=0, Busy=0, Valid=0.
  - Start=1 at an edge moves to SHIFT and clears Count to 0.
  - Ack is ignored.
- SHIFT:
  - Shift_En=1, Busy=1.
  - On every edge, sample both lanes: sa <= {A_In, sa[7:1]} and sb <= {B_In, sb[7:1]}. The first bit received lands in bit 0 after eight shifts.
  - Count increments by 1 per edge and wraps 7->0.
  - On the edge where Count==7: capture, load A_Data<=assembled sa, B_Data<=assembled sb, and move to DONE.
  - Start and Ack are ignored.
- DONE:
  - Valid=1, Busy=1, Shift_En=0.
  - A_Data/B_Data are held stable.
  - Ack=1 at an edge moves to IDLE. Start in the same cycle is ignored; a new transfer needs Start while in IDLE.
- A_Data/B_Data change only on the DONE-entry edge. They keep their last value through IDLE and subsequent SHIFT phases.
- Count reads 0 in DONE and IDLE.
- Reset (Reset_n=0, any time, including mid-SHIFT):
  - State goes to IDLE immediately.
  - Shift_En=0, Busy=0, Valid=0, Count=0, A_Data=0x00, B_Data=0x00, internal shift registers=0.
  - Partial data is discarded; there is no resume.
- Release of Reset_n is synchronized by the integrator; the block assumes release away from the clock edge.

## Timing
- Start high at edge E0 puts the block in SHIFT. Shift_En is high for cycles E0..E8 (exactly 8 cycles).
- The sender shifts on the same edges on which this block samples. The bit sampled at edge Ek (k=1..8) is sender bit k-1.
- Valid rises after edge E8. Latency from Start sample to Valid is 8 cycles.
- Minimum Valid width is 1 cycle, with Ack held high when entering DONE. Valid falls on the edge that samples Ack=1.
- Minimum transfer period is 10 cycles: 8 SHIFT + 1 DONE + 1 IDLE to sample the next Start.
- Start held high continuously gives back-to-back transfers once each DONE is acknowledged.

## Test plan
- Reset: hold Reset_n=0 with random inputs -> all outputs 0, and no Shift_En pulse for 5 cycles after release without Start.
- Basic transfer: sender loaded A=0x5A, B=0xC3, Start pulsed 1 cycle -> Shift_En high exactly 8 cycles, then Valid=1 with A_Data=0x5A, B_Data=0xC3 held until Ack. Ack for 1 cycle -> Valid=0 and state IDLE.
- Back-to-back: Start tied high, sender reloaded with 0xFF/0x00 then 0x01/0x80, Ack asserted 2 cycles after each Valid -> two transfers return exactly those bytes. Data is stable between transfers and Shift_En never exceeds 8 consecutive cycles.
- Ignored inputs: Start pulses during SHIFT and DONE, Ack pulses during IDLE and SHIFT -> no extra transfers, no early Valid drop, Count sequence 0..7 undisturbed.
- Mid-transfer reset: Reset_n low after 4 shift cycles -> immediate Shift_En=0, Count=0, A_Data/B_Data=0x00. A new transfer of 0xA5/0x3C then completes correctly.
- Simultaneous Start+Ack in DONE -> returns to IDLE, and no SHIFT occurs until Start is seen again in IDLE.
